// File: rtl/rf_scoreboard.sv
// rf_scoreboard: 32x32 GPR file with a per-register pending-write scoreboard
// for the ID-stage operand path. Committed values are readable the same cycle
// through write-through; busy flags tell hazard logic a writer is in flight.
// Optional macro RF_DEBUG_PORT_EN adds registered copies of each committed
// write on debug_rf_wen / debug_rf_wnum / debug_rf_wdata.
//
// Handshake: issue_valid and commit_valid are single-cycle qualifiers. An issue
// is accepted only in a cycle where issue_full is low; ID must hold the
// instruction while issue_full is high. A commit is always accepted.
module rf_scoreboard #(
    parameter int CNT_W = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic        issue_valid,
    input  logic        issue_wen,
    input  logic [4:0]  issue_waddr,
    output logic        issue_full,
    input  logic        commit_valid,
    input  logic        commit_wen,
    input  logic [4:0]  commit_waddr,
    input  logic [31:0] commit_wdata,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2,
    output logic        busy1,
    output logic        busy2,
`ifdef RF_DEBUG_PORT_EN
    output logic        debug_rf_wen,
    output logic [4:0]  debug_rf_wnum,
    output logic [31:0] debug_rf_wdata,
`endif
    output logic        sb_err
);

    logic [31:0]      gpr [32];
    logic [CNT_W-1:0] cnt [32];
    logic             issue_ev;
    logic             commit_ev;
    logic [31:0]      inc_vec;
    logic [31:0]      dec_vec;

    // Qualified issue/commit events; r0 is never tracked or written.
    always_comb begin
        issue_full = (&cnt[issue_waddr]) && (issue_waddr != 5'd0);
        issue_ev   = issue_valid && issue_wen && (issue_waddr != 5'd0) && !issue_full;
        commit_ev  = commit_valid && commit_wen && (commit_waddr != 5'd0);
        inc_vec    = '0;
        dec_vec    = '0;
        if (issue_ev)  inc_vec[issue_waddr]  = 1'b1;
        if (commit_ev) dec_vec[commit_waddr] = 1'b1;
    end

    // Register file write port; the write still lands during flush or underflow.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 32; i++) gpr[i] <= '0;
        end else if (commit_ev) begin
            gpr[commit_waddr] <= commit_wdata;
        end
    end

    // Pending-write counters: flush clears, issue+commit on one register cancels.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 32; i++) cnt[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < 32; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 32; i++) begin
                if (inc_vec[i] && !dec_vec[i]) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end else if (dec_vec[i] && !inc_vec[i] && (cnt[i] != '0)) begin
                    cnt[i] <= cnt[i] - 1'b1;
                end
            end
        end
    end

    // Sticky error: a commit arrived for a register with nothing pending.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sb_err <= 1'b0;
        end else if (commit_ev && (cnt[commit_waddr] == '0) && !inc_vec[commit_waddr]) begin
            sb_err <= 1'b1;
        end
    end

    // Read ports with write-through; busy drops when the last writer commits now.
    always_comb begin
        if (commit_ev && (raddr1 == commit_waddr)) rdata1 = commit_wdata;
        else                                       rdata1 = gpr[raddr1];
        if (commit_ev && (raddr2 == commit_waddr)) rdata2 = commit_wdata;
        else                                       rdata2 = gpr[raddr2];
        busy1 = (cnt[raddr1] != '0) &&
                !((cnt[raddr1] == CNT_W'(1)) && commit_ev && (commit_waddr == raddr1));
        busy2 = (cnt[raddr2] != '0) &&
                !((cnt[raddr2] == CNT_W'(1)) && commit_ev && (commit_waddr == raddr2));
    end

`ifdef RF_DEBUG_PORT_EN
    // Registered trace of each committed write, one cycle after the commit.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            debug_rf_wen   <= 1'b0;
            debug_rf_wnum  <= '0;
            debug_rf_wdata <= '0;
        end else if (commit_ev) begin
            debug_rf_wen   <= 1'b1;
            debug_rf_wnum  <= commit_waddr;
            debug_rf_wdata <= commit_wdata;
        end else begin
            debug_rf_wen   <= 1'b0;
            debug_rf_wnum  <= '0;
            debug_rf_wdata <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_rf_scoreboard.sv
// tb_rf_scoreboard: directed plus random stimulus against a reference model of
// the register file and its pending-writer counts; a monitor compares outputs.
module tb_rf_scoreboard;

    localparam int MAXP = 3;

    typedef struct packed {
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic        b1;
        logic        b2;
        logic        full;
        logic        err;
        logic        dwen;
        logic [4:0]  dwnum;
        logic [31:0] dwdata;
    } exp_t;
    localparam int W = $bits(exp_t);

    logic        clk;
    logic        resetn;
    logic        flush;
    logic        issue_valid, issue_wen;
    logic [4:0]  issue_waddr;
    logic        issue_full;
    logic        commit_valid, commit_wen;
    logic [4:0]  commit_waddr;
    logic [31:0] commit_wdata;
    logic [4:0]  raddr1, raddr2;
    logic [31:0] rdata1, rdata2;
    logic        busy1, busy2;
    logic        sb_err;
`ifdef RF_DEBUG_PORT_EN
    logic        debug_rf_wen;
    logic [4:0]  debug_rf_wnum;
    logic [31:0] debug_rf_wdata;
`endif

    rf_scoreboard #(.CNT_W(2)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .issue_valid(issue_valid), .issue_wen(issue_wen), .issue_waddr(issue_waddr),
        .issue_full(issue_full),
        .commit_valid(commit_valid), .commit_wen(commit_wen),
        .commit_waddr(commit_waddr), .commit_wdata(commit_wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
        .busy1(busy1), .busy2(busy2),
`ifdef RF_DEBUG_PORT_EN
        .debug_rf_wen(debug_rf_wen), .debug_rf_wnum(debug_rf_wnum),
        .debug_rf_wdata(debug_rf_wdata),
`endif
        .sb_err(sb_err)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    int          pend [32];
    logic [31:0] regs [32];
    bit          m_err;
    bit          m_dwen;
    logic [4:0]  m_dwnum;
    logic [31:0] m_dwdata;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            pend[i] = 0;
            regs[i] = '0;
        end
        m_err = 0; m_dwen = 0; m_dwnum = '0; m_dwdata = '0;
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] ra, input bit cev,
                                               input logic [4:0] ca, input logic [31:0] cd);
        if (ra == 5'd0) return '0;
        if (cev && ra == ca) return cd;
        return regs[ra];
    endfunction

    function automatic bit model_busy(input logic [4:0] ra, input bit cev, input logic [4:0] ca);
        if (ra == 5'd0 || pend[ra] == 0) return 0;
        if (pend[ra] == 1 && cev && ca == ra) return 0;
        return 1;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        flush = 0; issue_valid = 0; issue_wen = 0; issue_waddr = '0;
        commit_valid = 0; commit_wen = 0; commit_waddr = '0; commit_wdata = '0;
    endtask

    // Asynchronous reset asserted mid-cycle; outputs are checked while held low.
    task automatic do_reset(input logic [4:0] r1, input logic [4:0] r2);
        exp_t e;
        idle_inputs();
        raddr1 = r1; raddr2 = r2;
        resetn = 0;
        model_clear();
        e = '0;
        exp_q.push_back(W'(e));
        @(posedge clk);
        #1 resetn = 1;
    endtask

    task automatic step(input bit iv, input bit iw, input logic [4:0] ia,
                        input bit cv, input bit cw, input logic [4:0] ca,
                        input logic [31:0] cd, input logic [4:0] r1,
                        input logic [4:0] r2, input bit fl);
        exp_t e;
        bit full, iev, cev;
        issue_valid = iv; issue_wen = iw; issue_waddr = ia;
        commit_valid = cv; commit_wen = cw; commit_waddr = ca; commit_wdata = cd;
        raddr1 = r1; raddr2 = r2; flush = fl;
        full = (ia != 5'd0) && (pend[ia] == MAXP);
        iev  = iv && iw && (ia != 5'd0) && !full;
        cev  = cv && cw && (ca != 5'd0);
        e.rd1 = model_read(r1, cev, ca, cd);
        e.rd2 = model_read(r2, cev, ca, cd);
        e.b1 = model_busy(r1, cev, ca);
        e.b2 = model_busy(r2, cev, ca);
        e.full = full;
        e.err = m_err;
        e.dwen = m_dwen; e.dwnum = m_dwnum; e.dwdata = m_dwdata;
        exp_q.push_back(W'(e));
        @(posedge clk);
        if (cev) begin
            regs[ca] = cd;
            if (pend[ca] == 0 && !(iev && ia == ca)) m_err = 1;
        end
        if (fl) begin
            for (int i = 0; i < 32; i++) pend[i] = 0;
        end else begin
            if (iev) pend[ia] = pend[ia] + 1;
            if (cev && pend[ca] > 0) pend[ca] = pend[ca] - 1;
        end
        m_dwen = cev;
        m_dwnum = cev ? ca : 5'd0;
        m_dwdata = cev ? cd : 32'd0;
        #1;
    endtask

    // ---------------- scoreboard monitor ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_t'(exp_q.pop_front());
            check("rdata1", rdata1, e.rd1);
            check("rdata2", rdata2, e.rd2);
            check("busy1", 32'(busy1), 32'(e.b1));
            check("busy2", 32'(busy2), 32'(e.b2));
            check("issue_full", 32'(issue_full), 32'(e.full));
            check("sb_err", 32'(sb_err), 32'(e.err));
`ifdef RF_DEBUG_PORT_EN
            check("debug_rf_wen", 32'(debug_rf_wen), 32'(e.dwen));
            check("debug_rf_wnum", 32'(debug_rf_wnum), 32'(e.dwnum));
            check("debug_rf_wdata", debug_rf_wdata, e.dwdata);
`endif
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        idle_inputs();
        raddr1 = '0; raddr2 = '0;
        resetn = 0;
        model_clear();
        @(posedge clk);
        #1;
        do_reset(5'd0, 5'd0);

        // r5: two pending writers and a committed value, then reset mid-flight
        step(1,1,5, 0,0,0,0,       5,0, 0);
        step(1,1,5, 0,0,0,0,       5,0, 0);
        step(1,1,5, 1,1,5,32'h1234, 5,0, 0);
        step(0,0,0, 0,0,0,0,       5,0, 0);
        do_reset(5'd5, 5'd5);

        // r8: busy after issue, write-through on commit, settled afterwards
        step(1,1,8, 0,0,0,0,             0,0, 0);
        step(0,0,0, 0,0,0,0,             8,0, 0);
        step(0,0,0, 1,1,8,32'hDEADBEEF,  8,8, 0);
        step(0,0,0, 0,0,0,0,             8,8, 0);

        // r3: saturate, held issue, one commit frees a slot
        step(1,1,3, 0,0,0,0, 3,0, 0);
        step(1,1,3, 0,0,0,0, 3,0, 0);
        step(1,1,3, 0,0,0,0, 3,0, 0);
        step(1,1,3, 0,0,0,0, 3,0, 0);
        step(0,0,3, 1,1,3,32'h33, 3,0, 0);
        step(0,0,3, 0,0,0,0, 3,0, 0);

        // r9: same-cycle issue and commit leaves the count unchanged
        step(1,1,9, 0,0,0,0,        0,9, 0);
        step(1,1,9, 1,1,9,32'h99,   0,9, 0);
        step(0,0,0, 0,0,0,0,        9,9, 0);

        // r4: underflow commit, sticky across flush; r0 traffic ignored
        step(0,0,0, 1,1,4,32'hABC, 4,0, 0);
        step(0,0,0, 0,0,0,0,       4,0, 1);
        step(0,0,0, 0,0,0,0,       4,0, 0);
        step(1,1,0, 1,1,0,32'hFFFF_FFFF, 0,0, 0);
        step(0,0,0, 0,0,0,0,       0,0, 0);

        // flush with pending r1/r2 and a same-cycle issue
        do_reset(5'd0, 5'd0);
        step(1,1,1, 0,0,0,0, 1,2, 0);
        step(1,1,1, 0,0,0,0, 1,2, 0);
        step(1,1,2, 0,0,0,0, 1,2, 0);
        step(1,1,1, 0,0,0,0, 1,2, 1);
        step(0,0,0, 0,0,0,0, 1,2, 0);

        // r7 commit for the debug trace
        step(0,0,0, 1,1,7,32'h55, 7,0, 0);
        step(0,0,0, 0,0,0,0,      7,0, 0);

        // randomized traffic concentrated on a few registers
        for (int n = 0; n < 800; n++) begin
            bit iv, iw, cv, cw, fl;
            logic [4:0] ia, ca, r1, r2;
            logic [31:0] cd;
            if (n % 160 == 0) do_reset(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            iv = $urandom_range(0, 1) == 1;
            iw = $urandom_range(0, 3) != 0;
            ia = 5'($urandom_range(0, 7));
            cv = $urandom_range(0, 1) == 1;
            cw = $urandom_range(0, 3) != 0;
            ca = 5'($urandom_range(0, 7));
            cd = $urandom;
            r1 = ($urandom_range(0, 3) == 0) ? ca : 5'($urandom_range(0, 8));
            r2 = 5'($urandom_range(0, 8));
            fl = $urandom_range(0, 29) == 0;
            if (pend[ca] == 0 && (ia == ca || $urandom_range(0, 9) != 0)) cw = 0;
            step(iv, iw, ia, cv, cw, ca, cd, r1, r2, fl);
        end

        idle_inputs();
        begin
            int budget;
            budget = 10;
            while (exp_q.size() > 0 && budget > 0) begin
                @(posedge clk);
                budget--;
            end
            if (exp_q.size() > 0) begin
                errors++;
                $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_scoreboard.md
Name: rf_scoreboard

Overview:
- Register-file side of the ID-stage operand path: a 32x32 GPR file plus a per-register pending-write scoreboard.
- ID stage reads operands and busy flags here.
- Writers register intent at issue and retire it at WB commit.
- The forwarding/hazard logic uses busy1/busy2 to decide stall vs bypass. This block supplies committed values, with write-through on the commit cycle.

Parameters:
- CNT_W, 2, width of each per-register pending-write counter; max in-flight writers per register = 2^CNT_W-1.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- flush  in  1  pipeline flush; clears all pending counters
- issue_valid  in  1  an instruction leaves ID this cycle
- issue_wen  in  1  issuing instruction writes a GPR
- issue_waddr  in  5  destination of issuing instruction
- issue_full  out  1  counter for issue_waddr saturated; ID must hold
- commit_valid  in  1  WB instruction retires this cycle
- commit_wen  in  1  retiring instruction writes a GPR
- commit_waddr  in  5  retiring destination
- commit_wdata  in  32  retiring value
- raddr1  in  5  read address 1
- raddr2  in  5  read address 2
- rdata1  out  32  read data 1
- rdata2  out  32  read data 2
- busy1  out  1  raddr1 has in-flight writer(s) not yet visible
- busy2  out  1  raddr2 has in-flight writer(s) not yet visible
- sb_err  out  1  sticky: commit seen with zero pending count

Behaviour:
- Reset (resetn=0, async):
  - all 32 GPRs = 0; all counters = 0; sb_err = 0.
  - Outputs follow: rdata = 0, busy = 0, issue_full = 0.
- Register 0: never written, counter never changes, rdata = 0, busy = 0. Issue or commit to r0 is ignored; it raises no error.
- Write: at posedge, if commit_valid && commit_wen && commit_waddr != 0, GPR[commit_waddr] <= commit_wdata.
- Read (combinational):
  - If raddr == commit_waddr, the commit is an active write, and raddr != 0, then rdata = commit_wdata (write-through).
  - Otherwise rdata = GPR[raddr].
- Issue event: issue_valid && issue_wen && issue_waddr != 0 && !issue_full.
- Commit event: commit_valid && commit_wen && commit_waddr != 0.
- Counter update at posedge, per register r:
  - issue only: cnt[r]+1.
  - commit only: cnt[r]-1.
  - issue and commit on the same r: unchanged.
  - different registers: each updated independently.
- Underflow: a commit with cnt==0 leaves cnt at 0, sets sb_err; the GPR write still occurs.
- issue_full = (cnt[issue_waddr] == all-ones) && issue_waddr != 0. A gated issue does not increment.
- Simultaneous commit to the saturated register: issue_full is still asserted (conservative, no combinational path from commit to issue_full).
- busy1:
  - Base condition: cnt[raddr1] != 0.
  - Exception: if cnt[raddr1]==1 and a commit event targets raddr1 this cycle, busy1 = 0 (value available via write-through).
  - busy2 behaves identically.
- flush: at posedge, all counters <= 0. An issue or commit in the same cycle is discarded for counters, but the commit's GPR write still occurs. sb_err is unaffected.
- flush has priority over counter updates. resetn has priority over everything.
- sb_err clears only on reset.

Optional Feature:
- Macro: RF_DEBUG_PORT_EN.
- Defined: adds outputs debug_rf_wen(1), debug_rf_wnum(5), debug_rf_wdata(32).
  - These are registered copies of the committed write: one cycle after a commit event, wen=1 with its address and data; 0 otherwise.
  - All three reset to 0.
- Undefined: ports absent, no extra flops.

Test Plan:
- Reset mid-operation with cnt[5]=2 and GPR[5]=0x1234 -> immediately busy1=0 for raddr1=5, rdata1=0, sb_err=0.
- Issue r8, next cycle raddr1=8 -> busy1=1. Commit r8=0xDEADBEEF with raddr1=8 that cycle -> busy1=0, rdata1=0xDEADBEEF same cycle. Next cycle GPR[8]=0xDEADBEEF, cnt[8]=0.
- Issue r3 three times (CNT_W=2) -> issue_full=1. A fourth issue is held and cnt stays 3. One commit r3 -> cnt=2, issue_full=0.
- Same-cycle issue and commit of r9 with cnt[9]=1 -> cnt[9] stays 1, busy2=1 next cycle for raddr2=9.
- Commit r4 with cnt[4]=0 -> GPR[4] written, sb_err=1 persists after a flush. Issue/commit to r0 -> rdata=0, busy=0, sb_err unchanged.
- Flush with cnt[1]=2, cnt[2]=1 plus same-cycle issue r1 -> all counters 0 next cycle, busy1=busy2=0. With RF_DEBUG_PORT_EN, a commit r7=0x55 -> debug_rf_wen=1, wnum=7, wdata=0x55 one cycle later.
